led_bar_ctrl: RTL and testbench
===============================

Name: led_bar_ctrl

Overview:
- Sequences the multimeter's LED bar-graph driver and shares it between several measurement sources (e.g. voltage, current, resistance magnitude).
- Accepts samples only from the source chosen by `sel_i`, throttles bar updates to a fixed refresh rate, and optionally applies peak-hold with timed decay.
- Drives the bar driver's data, update-pulse and clear inputs.
- Sits between the measurement/scaling pipelines and the bar driver.

Parameters:
- DATA_W, 12: width of each source sample and of `bar_din_o`.
- SRC_NR, 3: number of sources, ≥2. SRC_W = $clog2(SRC_NR).
- HOLDOFF_CYC, 1000000: minimum cycles between bar updates. 0 disables holdoff.
- PEAK_HOLD_CYC, 50000000: cycles without a new peak before each decay step. ≥1.
- DECAY_STEP, 16: amount subtracted from the peak per decay step.

Ports:
- clk  in  1  system clock; one clock only.
- rst  in  1  reset, synchronous, active-high.
- sel_i  in  SRC_W  selected source index. Values ≥SRC_NR select nothing; all ready outputs are 1.
- src_data_i  in  SRC_NR*DATA_W  source samples; source k occupies bits [k*DATA_W +: DATA_W].
- src_valid_i  in  SRC_NR  per-source sample valid.
- src_ready_o  out  SRC_NR  per-source ready.
- peak_en_i  in  1  peak-hold enable.
- bar_din_o  out  DATA_W  value to bar driver.
- bar_update_o  out  1  one-cycle update strobe to bar driver.
- bar_clr_o  out  1  one-cycle clear strobe to bar driver.

Behaviour:
- All outputs are registered except `src_ready_o`, which is combinational from state, `sel_q` and `sel_i`.
- Reset (`rst`=1 at a clock edge):
  - state=IDLE; `bar_din_o`=0, `bar_update_o`=0, `bar_clr_o`=0.
  - Peak and both counters are cleared to 0.
  - `sel_q` is loaded from `sel_i`; no clear pulse follows reset.
  - Reset has priority over all other events.
- Handshake:
  - A transfer occurs when `src_valid_i[k]` & `src_ready_o[k]` are both 1.
  - Non-selected sources (k≠sel_q): `src_ready_o[k]`=1 always. Their samples are discarded, so upstream never stalls.
  - Selected source: ready=1 only in IDLE and only when `sel_i`==`sel_q`.
- FSM states: IDLE, UPDATE, HOLDOFF, CLEAR.
  - IDLE:
    - If `sel_i`≠`sel_q`, go to CLEAR.
    - Else, on a transfer from the selected source, capture the sample, update the peak, and go to UPDATE.
  - UPDATE (one cycle):
    - `bar_update_o`=1.
    - `bar_din_o` = peak if `peak_en_i`, else the captured sample.
    - Next state is CLEAR if `sel_i`≠`sel_q`; else HOLDOFF; or IDLE if HOLDOFF_CYC=0.
  - HOLDOFF:
    - Counter counts HOLDOFF_CYC cycles starting at the first HOLDOFF cycle, then goes to IDLE.
    - A `sel_i` change aborts the holdoff and goes to CLEAR.
  - CLEAR (one cycle):
    - `bar_clr_o`=1, `bar_din_o`<=0.
    - Peak<=0, decay counter<=0, `sel_q`<=`sel_i`.
    - Next state IDLE.
- Latency:
  - Transfer in cycle N gives `bar_update_o`=1 in cycle N+1.
  - Next transfer is possible at cycle N+2+HOLDOFF_CYC at the earliest.
- `bar_din_o` holds its last value between updates.
- Peak hold:
  - When `peak_en_i`=0: peak and decay counter are held at 0.
  - On capture with `peak_en_i`=1: if sample > peak, peak<=sample and the decay counter restarts at 0.
  - Otherwise the decay counter increments every cycle, in every state except CLEAR.
  - When the counter reaches PEAK_HOLD_CYC-1: peak <= (peak>DECAY_STEP) ? peak-DECAY_STEP : 0, saturating at 0, and the counter restarts.
  - A capture that raises the peak in the same cycle as decay expiry: the capture wins; the counter restarts.
  - Decay changes only the internal peak. `bar_din_o` changes only at UPDATE or CLEAR.
- Arithmetic: unsigned, DATA_W bits; no overflow is possible.

Test Plan:
Parameters for all scenarios: DATA_W=4, SRC_NR=3, HOLDOFF_CYC=4, PEAK_HOLD_CYC=8, DECAY_STEP=2.
1. Reset; `sel_i`=0, `peak_en_i`=0; src0 presents 9 with valid=1 -> transfer in cycle N. Cycle N+1: `bar_update_o`=1, `bar_din_o`=9. `src_ready_o[0]`=0 for cycles N+1..N+5; next accept at N+6.
2. `sel_i`=0; src1 and src2 stream valid data continuously -> `src_ready_o[2:1]`=2'b11 every cycle. `bar_update_o` never asserts; `bar_din_o` unchanged.
3. During HOLDOFF after showing 9, `sel_i` 0->1 -> next cycle `bar_clr_o`=1. Following cycle `bar_din_o`=0 and `src_ready_o[1]`=1. An src1 sample of 5 appears as an update with value 5.
4. `peak_en_i`=1; samples 12 then 3 -> updates show 12, then 12. With no larger sample for 8 cycles, peak becomes 10; a later sample 3 shows 10. Decay continues 10→8→…→0 and then stays 0.
5. Decay expiry coincides with a transfer of 13 while peak is 10 -> peak=13 (not 11); counter restarts; next update shows 13.
6. `rst`=1 mid-HOLDOFF, with a pending `sel_i` change -> next cycle all outputs are 0 and state is IDLE. No `bar_clr_o` pulse; `src_ready_o[sel_i]`=1.

Source files
------------

// File: rtl/led_bar_ctrl.sv
// led_bar_ctrl: shares one LED bar-graph driver between several measurement sources.
// Only the source picked by sel_i is accepted. Bar updates are throttled by a holdoff
// window. An optional peak-hold decays by DECAY_STEP each PEAK_HOLD_CYC idle cycles.
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   sel_i          selected source index (values >= SRC_NR select nothing)
//   src_data_i     packed source samples, source k at [k*DATA_W +: DATA_W]
//   src_valid_i    per-source sample valid
//   src_ready_o    per-source ready (combinational); non-selected sources are always ready
//   peak_en_i      peak-hold enable
//   bar_din_o      registered value to the bar driver
//   bar_update_o   registered one-cycle update strobe
//   bar_clr_o      registered one-cycle clear strobe
module led_bar_ctrl #(
    parameter int unsigned  DATA_W        = 12,
    parameter int unsigned  SRC_NR        = 3,
    parameter int unsigned  HOLDOFF_CYC   = 1000000,
    parameter int unsigned  PEAK_HOLD_CYC = 50000000,
    parameter int unsigned  DECAY_STEP    = 16,
    localparam int unsigned SRC_W         = $clog2(SRC_NR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SRC_W-1:0]         sel_i,
    input  logic [SRC_NR*DATA_W-1:0] src_data_i,
    input  logic [SRC_NR-1:0]        src_valid_i,
    output logic [SRC_NR-1:0]        src_ready_o,
    input  logic                     peak_en_i,
    output logic [DATA_W-1:0]        bar_din_o,
    output logic                     bar_update_o,
    output logic                     bar_clr_o
);

    localparam int unsigned HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam int unsigned PEAK_W = (PEAK_HOLD_CYC > 1) ? $clog2(PEAK_HOLD_CYC) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
    localparam logic [PEAK_W-1:0] PEAK_LAST = PEAK_W'(PEAK_HOLD_CYC - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StUpdate  = 2'd1;
    localparam logic [1:0] StHoldoff = 2'd2;
    localparam logic [1:0] StClear   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SRC_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [PEAK_W-1:0] decay_cnt_q, decay_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0] bar_din_q, bar_din_d;
    logic              bar_update_q, bar_update_d;
    logic              bar_clr_q, bar_clr_d;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_chg;
    logic              xfer;
    logic [31:0]       peak_ext;
    logic [DATA_W-1:0] peak_decayed;

    assign sel_chg = (sel_i != sel_q);

    // Out-of-range sel_q matches no source, leaving sel_valid low so no transfer occurs.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 0; k < SRC_NR; k++) begin
            if (sel_q == SRC_W'(k)) begin
                sel_data  = src_data_i[k*DATA_W +: DATA_W];
                sel_valid = src_valid_i[k];
            end
        end
    end

    // Non-selected sources are always drained so upstream never stalls.
    always_comb begin
        src_ready_o = '0;
        for (int unsigned k = 0; k < SRC_NR; k++) begin
            src_ready_o[k] = (sel_q != SRC_W'(k)) || ((state_q == StIdle) && !sel_chg);
        end
    end

    assign xfer = (state_q == StIdle) && !sel_chg && sel_valid;

    // Saturating decay computed in 32 bits so a large DECAY_STEP cannot wrap.
    assign peak_ext     = 32'(peak_q);
    assign peak_decayed = (peak_ext > DECAY_STEP) ? DATA_W'(peak_ext - DECAY_STEP) : '0;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        peak_d       = peak_q;
        decay_cnt_d  = decay_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        bar_din_d    = bar_din_q;
        bar_update_d = 1'b0;
        bar_clr_d    = 1'b0;

        // Peak tracking; a raising capture takes priority over a simultaneous decay expiry.
        if (!peak_en_i) begin
            peak_d      = '0;
            decay_cnt_d = '0;
        end else if (state_q != StClear) begin
            if (xfer && (sel_data > peak_q)) begin
                peak_d      = sel_data;
                decay_cnt_d = '0;
            end else if (decay_cnt_q == PEAK_LAST) begin
                peak_d      = peak_decayed;
                decay_cnt_d = '0;
            end else begin
                decay_cnt_d = decay_cnt_q + 1'b1;
            end
        end

        // Output strobes are registered, so they are raised on entry to their state.
        unique case (state_q)
            StIdle: begin
                if (sel_chg) begin
                    state_d   = StClear;
                    bar_clr_d = 1'b1;
                end else if (xfer) begin
                    state_d      = StUpdate;
                    bar_update_d = 1'b1;
                    bar_din_d    = peak_en_i ? peak_d : sel_data;
                end
            end
            StUpdate: begin
                hold_cnt_d = '0;
                if (sel_chg) begin
                    state_d   = StClear;
                    bar_clr_d = 1'b1;
                end else if (HOLDOFF_CYC == 0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (sel_chg) begin
                    state_d    = StClear;
                    bar_clr_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = StIdle;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StClear: begin
                state_d     = StIdle;
                bar_din_d   = '0;
                peak_d      = '0;
                decay_cnt_d = '0;
                sel_d       = sel_i;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= sel_i;
            peak_q       <= '0;
            decay_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            bar_din_q    <= '0;
            bar_update_q <= 1'b0;
            bar_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            peak_q       <= peak_d;
            decay_cnt_q  <= decay_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            bar_din_q    <= bar_din_d;
            bar_update_q <= bar_update_d;
            bar_clr_q    <= bar_clr_d;
        end
    end

    assign bar_din_o    = bar_din_q;
    assign bar_update_o = bar_update_q;
    assign bar_clr_o    = bar_clr_q;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// tb_led_bar_ctrl: self-checking bench for led_bar_ctrl with a small configuration
// (DATA_W=4, SRC_NR=3, HOLDOFF_CYC=4, PEAK_HOLD_CYC=8, DECAY_STEP=2).
// Expected bar values are queued when a transfer is seen and compared on each update strobe.
module tb_led_bar_ctrl;

    localparam int unsigned DATA_W        = 4;
    localparam int unsigned SRC_NR        = 3;
    localparam int unsigned HOLDOFF_CYC   = 4;
    localparam int unsigned PEAK_HOLD_CYC = 8;
    localparam int unsigned DECAY_STEP    = 2;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
        logic [3:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel_i;
    logic [11:0] src_data_i;
    logic [2:0]  src_valid_i;
    logic [2:0]  src_ready_o;
    logic        peak_en_i;
    logic [3:0]  bar_din_o;
    logic        bar_update_o;
    logic        bar_clr_o;

    logic [3:0]  d_src [3];
    logic [3:0]  sb [$];
    logic [3:0]  sb_exp;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign src_data_i = {d_src[2], d_src[1], d_src[0]};

    led_bar_ctrl #(
        .DATA_W        (DATA_W),
        .SRC_NR        (SRC_NR),
        .HOLDOFF_CYC   (HOLDOFF_CYC),
        .PEAK_HOLD_CYC (PEAK_HOLD_CYC),
        .DECAY_STEP    (DECAY_STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (sel_i),
        .src_data_i   (src_data_i),
        .src_valid_i  (src_valid_i),
        .src_ready_o  (src_ready_o),
        .peak_en_i    (peak_en_i),
        .bar_din_o    (bar_din_o),
        .bar_update_o (bar_update_o),
        .bar_clr_o    (bar_clr_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts just after a rising edge; returns just after the edge following the update cycle.
    task automatic send(input int src, input logic [3:0] d, input logic [3:0] exp);
        bit done;
        done = 1'b0;
        d_src[src]       = d;
        src_valid_i[src] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (src_ready_o[src] === 1'b1) begin
                sb.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        src_valid_i[src] = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: src %0d not ready, required ready within 50 cycles", src);
        end else begin
            @(negedge clk);
            chk("upd_latency", {31'd0, bar_update_o}, 32'd1);
            chk("ready_low_in_update", {31'd0, src_ready_o[src]}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every update strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bar_update_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: update with %0d, required no update", bar_din_o);
            end else begin
                sb_exp = sb.pop_front();
                chk("sb_bar_din", {28'd0, bar_din_o}, {28'd0, sb_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required $finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        vecs[0] = '{sel: 2'd1, data: 4'd11, exp: 4'd11};
        vecs[1] = '{sel: 2'd1, data: 4'd2,  exp: 4'd2};
        vecs[2] = '{sel: 2'd2, data: 4'd15, exp: 4'd15};
        vecs[3] = '{sel: 2'd2, data: 4'd0,  exp: 4'd0};
        vecs[4] = '{sel: 2'd0, data: 4'd6,  exp: 4'd6};
        vecs[5] = '{sel: 2'd1, data: 4'd8,  exp: 4'd8};

        rst         = 1'b1;
        sel_i       = 2'd0;
        peak_en_i   = 1'b0;
        src_valid_i = 3'b000;
        d_src[0]    = 4'd0;
        d_src[1]    = 4'd0;
        d_src[2]    = 4'd0;

        // Reset state
        cycles(3);
        @(negedge clk);
        chk("rst_din", {28'd0, bar_din_o}, 32'd0);
        chk("rst_upd", {31'd0, bar_update_o}, 32'd0);
        chk("rst_clr", {31'd0, bar_clr_o}, 32'd0);
        chk("rst_ready", {29'd0, src_ready_o}, 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_clr", {31'd0, bar_clr_o}, 32'd0);
        @(posedge clk);
        #1;

        // Basic transfer and holdoff window on src0
        send(0, 4'd9, 4'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("holdoff_ready0", {31'd0, src_ready_o[0]}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("reaccept_ready0", {31'd0, src_ready_o[0]}, 32'd1);
        @(posedge clk);
        #1;

        // Non-selected sources stream freely and never reach the bar
        for (int i = 0; i < 8; i++) begin
            d_src[1]    = 4'(i);
            d_src[2]    = 4'(15 - i);
            src_valid_i = 3'b110;
            @(negedge clk);
            chk("stream_ready", {30'd0, src_ready_o[2:1]}, 32'd3);
            chk("stream_no_upd", {31'd0, bar_update_o}, 32'd0);
            chk("stream_din", {28'd0, bar_din_o}, 32'd9);
            @(posedge clk);
            #1;
        end
        src_valid_i = 3'b000;

        // Source switch during holdoff
        send(0, 4'd9, 4'd9);
        sel_i = 2'd1;
        cycles(1);
        @(negedge clk);
        chk("switch_clr", {31'd0, bar_clr_o}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("switch_din0", {28'd0, bar_din_o}, 32'd0);
        chk("switch_ready1", {31'd0, src_ready_o[1]}, 32'd1);
        chk("switch_clr_done", {31'd0, bar_clr_o}, 32'd0);
        @(posedge clk);
        #1;
        send(1, 4'd5, 4'd5);

        // Table-driven transfers with peak hold off
        for (int i = 0; i < 6; i++) begin
            if (sel_i != vecs[i].sel) begin
                sel_i = vecs[i].sel;
                cycles(6);
                @(negedge clk);
                chk("tbl_clr_din", {28'd0, bar_din_o}, 32'd0);
                @(posedge clk);
                #1;
            end
            send(int'(vecs[i].sel), vecs[i].data, vecs[i].exp);
        end

        // Out-of-range select: every source ready, nothing displayed
        sel_i = 2'd3;
        cycles(4);
        for (int i = 0; i < 4; i++) begin
            d_src[0]    = 4'(i + 1);
            src_valid_i = 3'b111;
            @(negedge clk);
            chk("oor_ready", {29'd0, src_ready_o}, 32'd7);
            chk("oor_no_upd", {31'd0, bar_update_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        src_valid_i = 3'b000;
        sel_i       = 2'd0;
        cycles(4);

        // Peak hold and decay down to a saturated zero
        peak_en_i = 1'b1;
        send(0, 4'd12, 4'd12);
        send(0, 4'd3, 4'd12);
        send(0, 4'd3, 4'd10);
        cycles(60);
        send(0, 4'd1, 4'd1);

        // Capture of a larger sample coinciding with decay expiry
        send(0, 4'd12, 4'd12);
        cycles(14);
        send(0, 4'd13, 4'd13);
        cycles(5);
        send(0, 4'd3, 4'd13);
        peak_en_i = 1'b0;

        // Reset mid-holdoff with a pending source change
        sel_i = 2'd1;
        cycles(4);
        send(1, 4'd7, 4'd7);
        sel_i = 2'd2;
        rst   = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_din", {28'd0, bar_din_o}, 32'd0);
        chk("midrst_upd", {31'd0, bar_update_o}, 32'd0);
        chk("midrst_clr", {31'd0, bar_clr_o}, 32'd0);
        chk("midrst_ready", {29'd0, src_ready_o}, 32'd7);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_no_clr", {31'd0, bar_clr_o}, 32'd0);
        @(posedge clk);
        #1;
        send(2, 4'd6, 4'd6);

        cycles(8);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
